lpif_dstrm_protid_arb: RTL
==========================

Name: lpif_dstrm_protid_arb

Overview:
- Shares the single LPIF downstream channel (512-bit data, 2-bit protid) between NUM_REQ protocol-stack requesters.
- Round-robin grant at packet boundaries; grant is held until the requester's last flit.
- Gated by link-active state and a downstream flit-credit counter.
- Sits upstream of the user-interface block; its dstrm_* outputs drive that block's downstream inputs directly.

Parameters:
- NUM_REQ, 4, number of requesters (2..4); requester index i is sent as protid i.
- DATA_WIDTH, 512, flit data width.
- CREDIT_WIDTH, 8, credit counter width.

Ports:
- clk_wr  in  1  single clock for all logic.
- rst_wr  in  1  reset, synchronous, active-high.
- link_active  in  1  high when the link is online (tx_online and rx_online delayed).
- init_downstream_credit  in  CREDIT_WIDTH  credit count loaded at link-up.
- credit_return  in  1  one-cycle pulse returning one credit.
- req_valid  in  NUM_REQ  per-requester flit valid.
- req_last  in  NUM_REQ  per-requester last flit of packet.
- req_data  in  NUM_REQ*DATA_WIDTH  flit data; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept (at most one bit high).
- dstrm_valid  out  1  registered flit valid.
- dstrm_dvalid  out  1  equals dstrm_valid.
- dstrm_protid  out  2  index of the requester that sent the flit.
- dstrm_data  out  DATA_WIDTH  registered flit data.
- arb_debug_status  out  32  {credit_cnt[7:0], grant_idx[1:0], state[1:0], sticky_abort, 19'h0}.

Behaviour:
- Reset values: all outputs 0; state DOWN; rr_ptr 0; credit_cnt 0; sticky_abort 0.
- Accept: a flit is accepted when req_valid[i] and req_ready[i] are both high.
- req_ready[i] is high only when all of the following hold:
  - state is IDLE or BUSY;
  - link_active is 1;
  - credit_cnt != 0;
  - i is the current winner.
- Winner selection:
  - IDLE: combinational round-robin among req_valid, starting at rr_ptr.
  - BUSY: the locked grant_idx.
- States:
  - DOWN: no grants. Transition to IDLE when link_active=1; on that transition credit_cnt <= init_downstream_credit.
  - IDLE: on accept with req_last=0, go to BUSY and lock grant_idx=i. On accept with req_last=1, stay IDLE and set rr_ptr=(i+1)%NUM_REQ.
  - BUSY: on accept with req_last=1, go to IDLE and set rr_ptr=(grant_idx+1)%NUM_REQ. Other requesters are never granted while BUSY.
  - Any state: if link_active=0, go to DOWN next cycle and set credit_cnt=0. If this happens in BUSY, set sticky_abort=1; it clears only on reset.
- Latency: one cycle. In the cycle after an accept, dstrm_valid=dstrm_dvalid=1, dstrm_protid=winner index and dstrm_data=accepted data. Otherwise dstrm_valid=0 and data/protid hold their last values.
- Credits:
  - Accept only: decrement by 1.
  - credit_return only: increment by 1, saturating at 2^CREDIT_WIDTH-1.
  - Accept and credit_return in the same cycle: unchanged.
  - credit_return in DOWN: ignored.
  - Credit return does not bypass to ready: ready follows the registered credit_cnt.
- Bubbles in BUSY (req_valid low from the holder) keep the grant locked; there is no timeout.
- A single-flit packet (last=1 on the first flit) never enters BUSY.

Decomposition:
- Package lpif_arb_pkg holds:
  - state enum arb_state_e {DOWN, IDLE, BUSY};
  - debug-status field offset constants.
- Sub-module lpif_rr_pick: combinational round-robin priority picker (req vector and pointer in; one-hot and index out). Used once here; reusable by the upstream demux.

Test Plan:
- Link-up credit load: init_downstream_credit=8'd3, link_active 0->1 -> credit_cnt=3 after one cycle; arb_debug_status[31:24]=3.
- Round-robin, single-flit packets: req_valid=4'b1111, all last=1, 8 credits -> protid sequence 0,1,2,3,0,1,2,3; one flit per cycle; dstrm_valid one cycle after each ready.
- Grant lock: req0 sends a 4-flit packet while req1 is valid throughout -> 4 consecutive protid=0 flits, then protid=1; a bubble on req0 in flit 2 does not grant req1.
- Credit exhaustion and simultaneous events: credits=2 with continuous traffic -> 2 flits then ready=0. A credit_return pulse -> exactly 1 more flit. Accept with a return in the same cycle -> count unchanged.
- Link drop mid-packet: link_active=0 during flit 2 of 4 -> ready=0 next cycle; state DOWN; credit_cnt=0; sticky_abort=1. After link re-up the requester restarts, and sticky_abort stays 1 until rst_wr.
- Synchronous reset mid-traffic: rst_wr high for 1 cycle in BUSY -> all outputs 0, state DOWN, rr_ptr 0 at the next edge.

Source files
------------

// File: rtl/lpif_arb_pkg.sv
// Shared types and constants for the LPIF downstream protocol-ID arbiter.
package lpif_arb_pkg;

   typedef enum logic [1:0] {
      DOWN = 2'd0,
      IDLE = 2'd1,
      BUSY = 2'd2
   } arb_state_e;

   // Field positions inside arb_debug_status
   localparam int unsigned DBG_CREDIT_LSB = 24;
   localparam int unsigned DBG_GRANT_LSB  = 22;
   localparam int unsigned DBG_STATE_LSB  = 20;
   localparam int unsigned DBG_STICKY_BIT = 19;

endpackage

// File: rtl/lpif_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module lpif_rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt_oh,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_any
);

   always_comb begin
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] cand;
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      sum     = '0;
      cand    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(N)) begin
            sum = sum - (IDX_W+1)'(N);
         end
         cand = sum[IDX_W-1:0];
         if (!gnt_any && req[cand]) begin
            gnt_any      = 1'b1;
            gnt_idx      = cand;
            gnt_oh[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lpif_dstrm_protid_arb.sv
// Round-robin, packet-locked arbiter sharing the LPIF downstream channel among
// protocol-stack requesters, gated by link state and a flit-credit counter.
module lpif_dstrm_protid_arb
   import lpif_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned DATA_WIDTH   = 512,
   parameter int unsigned CREDIT_WIDTH = 8
) (
   input  logic                          clk_wr,
   input  logic                          rst_wr,
   input  logic                          link_active,
   input  logic [CREDIT_WIDTH-1:0]       init_downstream_credit,
   input  logic                          credit_return,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          dstrm_valid,
   output logic                          dstrm_dvalid,
   output logic [1:0]                    dstrm_protid,
   output logic [DATA_WIDTH-1:0]         dstrm_data,
   output logic [31:0]                   arb_debug_status
);

   arb_state_e              state_q, state_d;
   logic [1:0]              rr_ptr_q, rr_ptr_d;
   logic [1:0]              grant_idx_q, grant_idx_d;
   logic [CREDIT_WIDTH-1:0] credit_cnt_q, credit_cnt_d;
   logic                    sticky_abort_q, sticky_abort_d;
   logic                    out_valid_q, out_valid_d;
   logic [1:0]              out_protid_q, out_protid_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

   logic [DATA_WIDTH-1:0]   req_data_a [NUM_REQ];
   logic [NUM_REQ-1:0]      pick_oh;
   logic [1:0]              pick_idx;
   logic                    pick_any;
   logic [1:0]              win_idx;
   logic                    can_grant;
   logic                    accept;
   logic                    acc_last;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
      assign req_data_a[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   lpif_rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (2)
   ) u_pick (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .gnt_oh  (pick_oh),
      .gnt_idx (pick_idx),
      .gnt_any (pick_any)
   );

   // Ready follows registered credit; a same-cycle credit_return does not bypass.
   always_comb begin
      can_grant = (state_q != DOWN) && link_active && (credit_cnt_q != '0);
      req_ready = '0;
      win_idx   = pick_idx;
      if (state_q == BUSY) begin
         win_idx = grant_idx_q;
         if (can_grant) begin
            req_ready[grant_idx_q] = 1'b1;
         end
      end else if (can_grant) begin
         req_ready = pick_oh;
      end
      accept   = |(req_valid & req_ready);
      acc_last = req_last[win_idx];
   end

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      grant_idx_d    = grant_idx_q;
      credit_cnt_d   = credit_cnt_q;
      sticky_abort_d = sticky_abort_q;
      out_valid_d    = 1'b0;
      out_protid_d   = out_protid_q;
      out_data_d     = out_data_q;

      if (state_q == DOWN) begin
         if (link_active) begin
            state_d      = IDLE;
            credit_cnt_d = init_downstream_credit;
         end
      end else if (!link_active) begin
         state_d      = DOWN;
         credit_cnt_d = '0;
         if (state_q == BUSY) begin
            sticky_abort_d = 1'b1;
         end
      end else begin
         if (accept && !credit_return) begin
            credit_cnt_d = credit_cnt_q - 1'b1;
         end else if (credit_return && !accept && (credit_cnt_q != '1)) begin
            credit_cnt_d = credit_cnt_q + 1'b1;
         end
         if (accept) begin
            out_valid_d  = 1'b1;
            out_protid_d = win_idx;
            out_data_d   = req_data_a[win_idx];
            grant_idx_d  = win_idx;
            if (acc_last) begin
               state_d  = IDLE;
               rr_ptr_d = (win_idx == 2'(NUM_REQ-1)) ? 2'd0 : win_idx + 2'd1;
            end else begin
               state_d = BUSY;
            end
         end
      end
   end

   always_ff @(posedge clk_wr) begin
      if (rst_wr) begin
         state_q        <= DOWN;
         rr_ptr_q       <= '0;
         grant_idx_q    <= '0;
         credit_cnt_q   <= '0;
         sticky_abort_q <= 1'b0;
         out_valid_q    <= 1'b0;
         out_protid_q   <= '0;
         out_data_q     <= '0;
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         grant_idx_q    <= grant_idx_d;
         credit_cnt_q   <= credit_cnt_d;
         sticky_abort_q <= sticky_abort_d;
         out_valid_q    <= out_valid_d;
         out_protid_q   <= out_protid_d;
         out_data_q     <= out_data_d;
      end
   end

   always_comb begin
      arb_debug_status                              = '0;
      arb_debug_status[DBG_CREDIT_LSB +: 8]         = 8'(credit_cnt_q);
      arb_debug_status[DBG_GRANT_LSB +: 2]          = grant_idx_q;
      arb_debug_status[DBG_STATE_LSB +: 2]          = state_q;
      arb_debug_status[DBG_STICKY_BIT]              = sticky_abort_q;
   end

   assign dstrm_valid  = out_valid_q;
   assign dstrm_dvalid = out_valid_q;
   assign dstrm_protid = out_protid_q;
   assign dstrm_data   = out_data_q;

endmodule
